// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
//   Shared types and constants for the clock datapath field counters.
//   bcd_digit_t    : one BCD digit (0..9 in a 4-bit container)
//   repeat_state_t : per-button auto-repeat state
//   BCD_MAX        : largest value two BCD digits can show
// ---------------------------------------------------------------------------
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_FIRST,
        RPT_HOLD,
        RPT_REPEAT
    } repeat_state_t;

    localparam int BCD_MAX = 99;

endpackage

// File: rtl/bcd_split.sv
// ---------------------------------------------------------------------------
// bcd_split
//   Combinational binary -> two-digit BCD split, shared by all field counters.
//   Ports:
//     bin   in  W  binary value, expected range 0..99
//     tens  out 4  bin / 10
//     units out 4  bin % 10
// ---------------------------------------------------------------------------
module bcd_split
    import clock_pkg::*;
#(
    parameter int W = 7
) (
    input  logic [W-1:0] bin,
    output bcd_digit_t   tens,
    output bcd_digit_t   units
);

    logic [31:0] bin_ext;

    // Division by a constant; synthesis reduces this to a small combinational net.
    always_comb begin
        bin_ext = 32'(bin);
        tens    = bcd_digit_t'(bin_ext / 32'd10);
        units   = bcd_digit_t'(bin_ext % 32'd10);
    end

endmodule

// File: rtl/time_field_counter.sv
// ---------------------------------------------------------------------------
// time_field_counter
//   Generic time field (seconds/minutes/hours/days/months). Counts from
//   MIN_VAL up to a runtime-limited maximum, exposes binary and BCD views,
//   and emits a registered carry pulse when it wraps in count mode.
//   Set mode steps the value with inc/dec buttons (wrapping both ways).
//   Optional build macro: HOLD_REPEAT_EN enables button auto-repeat.
//   Ports:
//     clk_1s    in  1  clock, all state changes on rising edge
//     rstn      in  1  synchronous active-low reset
//     count_en  in  1  carry-in / tick, advances by one in count mode
//     set_mode  in  1  1 = set mode (inc/dec active, count_en ignored)
//     inc, dec  in  1  level buttons, rising edge = one step
//     load      in  1  strobe: value <= load_val limited to legal range
//     load_val  in  W  load data
//     max_val   in  W  runtime upper limit
//     value     out W  current binary value
//     tens      out 4  BCD tens digit
//     units     out 4  BCD units digit
//     at_max    out 1  value equals effective maximum
//     carry_out out 1  one-cycle pulse on wrap to MIN_VAL in count mode
// ---------------------------------------------------------------------------
module time_field_counter
    import clock_pkg::*;
#(
    parameter int MIN_VAL    = 0,
    parameter int MAX_VAL    = 59,
    parameter int RST_VAL    = 0,
    parameter int W          = 7,
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic         clk_1s,
    input  logic         rstn,
    input  logic         count_en,
    input  logic         set_mode,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] max_val,
    output logic [W-1:0] value,
    output bcd_digit_t   tens,
    output bcd_digit_t   units,
    output logic         at_max,
    output logic         carry_out
);

    if (MAX_VAL > BCD_MAX || MIN_VAL > MAX_VAL || RST_VAL < MIN_VAL ||
        RST_VAL > MAX_VAL || (1 << W) <= MAX_VAL ||
        REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
        $error("time_field_counter: illegal parameter combination");
    end

    localparam logic [W-1:0] MIN_W = W'(MIN_VAL);
    localparam logic [W-1:0] MAX_W = W'(MAX_VAL);
    localparam logic [W-1:0] RST_W = W'(RST_VAL);

    // Buttons as a vector: bit 0 = inc, bit 1 = dec.
    logic [1:0] btn;
    logic [1:0] btn_q;
    logic [1:0] press;
    logic [1:0] step;

    assign btn   = {dec, inc};
    assign press = btn & ~btn_q & {2{set_mode}};

    // NOTE: reset is synchronous, so it is only tested inside the clocked block.
    always_ff @(posedge clk_1s) begin
        if (!rstn) begin
            btn_q <= '0;
        end else begin
            // NOTE: non-blocking assignment for every state register.
            btn_q <= btn;
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam int RC_W = $clog2(REPEAT_DLY + REPEAT_PER + 1);

    repeat_state_t   rpt_q [2];
    repeat_state_t   rpt_d [2];
    logic [RC_W-1:0] cnt_q [2];
    logic [RC_W-1:0] cnt_d [2];

    always_ff @(posedge clk_1s) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                rpt_q[i] <= RPT_IDLE;
                cnt_q[i] <= '0;
            end else begin
                rpt_q[i] <= rpt_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // HOLD counts held cycles until REPEAT_DLY have elapsed; REPEAT then
    // emits a step whenever its phase counter is back at zero.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // NOTE: defaults first so no path leaves a variable unassigned (no latch).
            rpt_d[i] = rpt_q[i];
            cnt_d[i] = cnt_q[i];
            step[i]  = 1'b0;
            unique case (rpt_q[i])
                RPT_IDLE: begin
                    if (press[i]) rpt_d[i] = RPT_FIRST;
                end
                RPT_FIRST: begin
                    step[i]  = 1'b1;
                    rpt_d[i] = RPT_HOLD;
                    cnt_d[i] = RC_W'(1);
                end
                RPT_HOLD: begin
                    if (cnt_q[i] >= RC_W'(REPEAT_DLY - 1)) begin
                        rpt_d[i] = RPT_REPEAT;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + RC_W'(1);
                    end
                end
                RPT_REPEAT: begin
                    step[i]  = (cnt_q[i] == '0);
                    cnt_d[i] = (cnt_q[i] == RC_W'(REPEAT_PER - 1)) ? '0 : cnt_q[i] + RC_W'(1);
                end
                default: rpt_d[i] = RPT_IDLE;
            endcase
            if (rpt_q[i] != RPT_IDLE && (!btn[i] || !set_mode)) begin
                rpt_d[i] = RPT_IDLE;
                cnt_d[i] = '0;
            end
        end
    end
`else
    // One step per press, applied the cycle after the edge is sampled.
    logic [1:0] pend_q;

    always_ff @(posedge clk_1s) begin
        if (!rstn) pend_q <= '0;
        else       pend_q <= press;
    end

    assign step = pend_q;
`endif

    logic [W-1:0] eff_max;
    logic [W-1:0] load_lim;
    logic [W-1:0] value_d;
    logic         carry_d;

    always_comb begin
        if (max_val >= MAX_W)      eff_max = MAX_W;
        else if (max_val <= MIN_W) eff_max = MIN_W;
        else                       eff_max = max_val;

        if (load_val <= MIN_W)        load_lim = MIN_W;
        else if (load_val >= eff_max) load_lim = eff_max;
        else                          load_lim = load_val;
    end

    assign at_max = (value == eff_max);

    // Priority: load > clamp > set-mode step > count.
    always_comb begin
        value_d = value;
        carry_d = 1'b0;
        if (load) begin
            value_d = load_lim;
        end else if (value > eff_max) begin
            value_d = eff_max;
        end else if (set_mode) begin
            if (step[0] && !step[1])
                value_d = at_max ? MIN_W : value + W'(1);
            else if (step[1] && !step[0])
                value_d = (value == MIN_W) ? eff_max : value - W'(1);
        end else if (count_en) begin
            if (at_max) begin
                value_d = MIN_W;
                carry_d = 1'b1;
            end else begin
                value_d = value + W'(1);
            end
        end
    end

    always_ff @(posedge clk_1s) begin
        if (!rstn) begin
            value     <= RST_W;
            carry_out <= 1'b0;
        end else begin
            value     <= value_d;
            carry_out <= carry_d;
        end
    end

    bcd_split #(.W(W)) u_bcd (
        .bin   (value),
        .tens  (tens),
        .units (units)
    );

endmodule

// File: tb/tb_time_field_counter.sv
// ---------------------------------------------------------------------------
// tb_time_field_counter
//   Two instances: A = seconds-style field (0..59), B = day-style field
//   (1..31). Directed scenarios followed by randomized stimulus, each cycle
//   compared against a reference model that tracks how long each button has
//   been held and derives the steps from that.
// ---------------------------------------------------------------------------
module tb_time_field_counter;

    localparam int DLY   = 8;
    localparam int PER   = 4;
    localparam int A_MIN = 0;
    localparam int A_MAX = 59;
    localparam int A_RST = 0;
    localparam int A_W   = 7;
    localparam int B_MIN = 1;
    localparam int B_MAX = 31;
    localparam int B_RST = 1;
    localparam int B_W   = 5;

    typedef struct {
        bit count_en;
        bit set_mode;
        bit inc;
        bit dec;
        bit load;
        int load_val;
        int max_val;
    } drv_t;

    typedef struct {
        int v;
        bit c;
        int n_inc;
        int n_dec;
        bit p_inc;
        bit p_dec;
    } mdl_t;

    logic clk_1s = 1'b0;
    logic rstn;
    drv_t da, db;
    mdl_t ma, mb;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_1s = ~clk_1s;

    logic [A_W-1:0] a_load_val, a_max_val, a_value;
    logic [3:0]     a_tens, a_units;
    logic           a_at_max, a_carry;
    logic [B_W-1:0] b_load_val, b_max_val, b_value;
    logic [3:0]     b_tens, b_units;
    logic           b_at_max, b_carry;

    assign a_load_val = A_W'(da.load_val);
    assign a_max_val  = A_W'(da.max_val);
    assign b_load_val = B_W'(db.load_val);
    assign b_max_val  = B_W'(db.max_val);

    time_field_counter #(
        .MIN_VAL(A_MIN), .MAX_VAL(A_MAX), .RST_VAL(A_RST), .W(A_W),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut_a (
        .clk_1s(clk_1s), .rstn(rstn), .count_en(da.count_en), .set_mode(da.set_mode),
        .inc(da.inc), .dec(da.dec), .load(da.load), .load_val(a_load_val),
        .max_val(a_max_val), .value(a_value), .tens(a_tens), .units(a_units),
        .at_max(a_at_max), .carry_out(a_carry)
    );

    time_field_counter #(
        .MIN_VAL(B_MIN), .MAX_VAL(B_MAX), .RST_VAL(B_RST), .W(B_W),
        .REPEAT_DLY(DLY), .REPEAT_PER(PER)
    ) dut_b (
        .clk_1s(clk_1s), .rstn(rstn), .count_en(db.count_en), .set_mode(db.set_mode),
        .inc(db.inc), .dec(db.dec), .load(db.load), .load_val(b_load_val),
        .max_val(b_max_val), .value(b_value), .tens(b_tens), .units(b_units),
        .at_max(b_at_max), .carry_out(b_carry)
    );

    task automatic check(input string tag, input logic [31:0] got, input int exp);
        n_checks++;
        if (got !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int eff_of(input int mv, input int mn, input int mx);
        int e;
        e = (mv < mx) ? mv : mx;
        return (e < mn) ? mn : e;
    endfunction

    // Does a button that has been held for n cycles (n=1 first) produce a step?
    function automatic bit step_of(input int n);
`ifdef HOLD_REPEAT_EN
        return (n == 1) || (n > DLY && ((n - DLY - 1) % PER) == 0);
`else
        return (n == 1);
`endif
    endfunction

    function automatic int hold_next(input int n, input bit prev, input bit btn, input bit sm);
        if (!(sm && btn)) return 0;
        if (n > 0)        return n + 1;
        return prev ? 0 : 1;
    endfunction

    function automatic mdl_t model_edge(input mdl_t m, input drv_t d, input bit rst_ok,
                                        input int mn, input int mx, input int rv);
        mdl_t r;
        int   em;
        bit   si, sd;
        r = m;
        if (!rst_ok) begin
            r = '{v: rv, c: 1'b0, n_inc: 0, n_dec: 0, p_inc: 1'b0, p_dec: 1'b0};
            return r;
        end
        em  = eff_of(d.max_val, mn, mx);
        si  = step_of(m.n_inc);
        sd  = step_of(m.n_dec);
        r.c = 1'b0;
        if (d.load) begin
            r.v = (d.load_val < mn) ? mn : (d.load_val > em) ? em : d.load_val;
        end else if (m.v > em) begin
            r.v = em;
        end else if (d.set_mode) begin
            if (si && !sd)      r.v = (m.v == em) ? mn : m.v + 1;
            else if (sd && !si) r.v = (m.v == mn) ? em : m.v - 1;
        end else if (d.count_en) begin
            if (m.v == em) begin
                r.v = mn;
                r.c = 1'b1;
            end else begin
                r.v = m.v + 1;
            end
        end
        r.n_inc = hold_next(m.n_inc, m.p_inc, d.inc, d.set_mode);
        r.n_dec = hold_next(m.n_dec, m.p_dec, d.dec, d.set_mode);
        r.p_inc = d.inc;
        r.p_dec = d.dec;
        return r;
    endfunction

    task automatic check_all();
        check("a.value",  32'(a_value),  ma.v);
        check("a.tens",   32'(a_tens),   ma.v / 10);
        check("a.units",  32'(a_units),  ma.v % 10);
        check("a.at_max", 32'(a_at_max), int'(ma.v == eff_of(da.max_val, A_MIN, A_MAX)));
        check("a.carry",  32'(a_carry),  int'(ma.c));
        check("b.value",  32'(b_value),  mb.v);
        check("b.tens",   32'(b_tens),   mb.v / 10);
        check("b.units",  32'(b_units),  mb.v % 10);
        check("b.at_max", 32'(b_at_max), int'(mb.v == eff_of(db.max_val, B_MIN, B_MAX)));
        check("b.carry",  32'(b_carry),  int'(mb.c));
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk_1s);
        ma = model_edge(ma, da, rstn, A_MIN, A_MAX, A_RST);
        mb = model_edge(mb, db, rstn, B_MIN, B_MAX, B_RST);
        @(negedge clk_1s);
        check_all();
    endtask

    function automatic drv_t idle_drv(input int maxv);
        drv_t d;
        d = '{count_en: 1'b0, set_mode: 1'b0, inc: 1'b0, dec: 1'b0, load: 1'b0,
              load_val: 0, max_val: maxv};
        return d;
    endfunction

    task automatic rand_drv(inout drv_t d, input int w, input int maxv);
        d.count_en = 1'($urandom_range(1));
        if ($urandom_range(39) == 0) d.set_mode = ~d.set_mode;
        if ($urandom_range(4) == 0)  d.inc = ~d.inc;
        if ($urandom_range(4) == 0)  d.dec = ~d.dec;
        d.load     = ($urandom_range(19) == 0);
        d.load_val = int'($urandom_range((1 << w) - 1));
        if ($urandom_range(9) == 0)       d.max_val = int'($urandom_range((1 << w) - 1));
        else if ($urandom_range(9) == 0)  d.max_val = maxv;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        da   = idle_drv(A_MAX);
        db   = idle_drv(B_MAX);
        ma   = '{v: 0, c: 1'b0, n_inc: 0, n_dec: 0, p_inc: 1'b0, p_dec: 1'b0};
        mb   = ma;
        rstn = 1'b0;
        tick();
        rstn = 1'b1;

        // Reset from a non-reset value.
        da.load = 1'b1; da.load_val = 37; tick(); da.load = 1'b0;
        check("preload 37", 32'(a_value), 37);
        rstn = 1'b0; tick(); rstn = 1'b1;
        check("reset value", 32'(a_value), 0);
        check("reset tens",  32'(a_tens),  0);
        check("reset units", 32'(a_units), 0);
        check("reset carry", 32'(a_carry), 0);
        check("reset b",     32'(b_value), 1);

        // Count wrap with carry pulse.
        da.load = 1'b1; da.load_val = 59; tick(); da.load = 1'b0;
        check("at_max 59", 32'(a_at_max), 1);
        da.count_en = 1'b1; tick(); da.count_en = 1'b0;
        check("wrap value", 32'(a_value), 0);
        check("wrap carry", 32'(a_carry), 1);
        tick();
        check("carry one cycle", 32'(a_carry), 0);

        // Set mode: inc wrap, dec wrap, both together, count_en ignored.
        da.set_mode = 1'b1; da.load = 1'b1; da.load_val = 59; tick(); da.load = 1'b0;
        da.inc = 1'b1; tick(); da.inc = 1'b0; tick();
        check("inc wrap", 32'(a_value), 0);
        da.dec = 1'b1; tick(); da.dec = 1'b0; tick();
        check("dec wrap", 32'(a_value), 59);
        da.inc = 1'b1; da.dec = 1'b1; tick(); da.inc = 1'b0; da.dec = 1'b0; tick();
        check("inc+dec", 32'(a_value), 59);
        da.count_en = 1'b1; repeat (3) tick(); da.count_en = 1'b0;
        check("set ignores count", 32'(a_value), 59);
        check("set carry", 32'(a_carry), 0);
        da.set_mode = 1'b0;

        // Runtime limit drop clamps, then wrap at the new limit.
        db.load = 1'b1; db.load_val = 31; tick(); db.load = 1'b0;
        db.max_val = 28; tick();
        check("clamp value", 32'(b_value), 28);
        check("clamp carry", 32'(b_carry), 0);
        db.count_en = 1'b1; tick(); db.count_en = 1'b0;
        check("limit wrap", 32'(b_value), 1);
        check("limit carry", 32'(b_carry), 1);
        db.max_val = B_MAX;

        // Load limiting and load priority over count_en.
        da.load = 1'b1; da.load_val = 75; tick();
        check("load limit", 32'(a_value), 59);
        da.load_val = 10; da.count_en = 1'b1; tick();
        da.load = 1'b0; da.count_en = 1'b0;
        check("load wins", 32'(a_value), 10);
        check("load carry", 32'(a_carry), 0);

        // Button held for 20 cycles.
        da.set_mode = 1'b1; da.load = 1'b1; da.load_val = 10; tick(); da.load = 1'b0;
        da.inc = 1'b1; repeat (20) tick(); da.inc = 1'b0; repeat (6) tick();
`ifdef HOLD_REPEAT_EN
        check("held repeat", 32'(a_value), 14);
`else
        check("held single", 32'(a_value), 11);
`endif
        da.set_mode = 1'b0;

        // Randomized phase.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rstn = ($urandom_range(149) != 0);
            rand_drv(da, A_W, A_MAX);
            rand_drv(db, B_W, B_MAX);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
